sevenseg_bcd_display: RTL and testbench

//  Parametrised N-digit decimal seven-segment driver. Next generation of the per-digit HEX path.

---
 rtl/sevenseg_bcd_display.sv | 165 ++++++++++++++++
 tb/tb_sevenseg_bcd_display.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_bcd_display.sv
// N-digit decimal seven-segment driver.
// A binary value arrives over a valid/ready handshake. An iterative
// shift-add-3 (double dabble) engine turns it into BCD one bit per clock.
// The registered BCD digits are then decoded to segments, with leading-zero
// blanking, an overflow dash display and a free-running blink timebase.
module sevenseg_bcd_display #(
  parameter int NUM_DIGITS = 8,
  parameter int IN_WIDTH   = 32,
  parameter int BLINK_DIV  = 25_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    iClk,
  input  logic                    nRst,
  input  logic [IN_WIDTH-1:0]     iNum,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic                    iBlink,
  input  logic                    iBlankLZ,
  output logic [7*NUM_DIGITS-1:0] oSeg,
  output logic                    oDone,
  output logic                    oOverflow,
  output logic [1:0]              dbg_state
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int DW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] LAST_BIT  = CW'(IN_WIDTH - 1);
  localparam logic [DW-1:0] BLINK_TOP = DW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_DASH  = 7'b1000000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] bin_q;
  logic [BW-1:0]       work_q;
  logic [CW-1:0]       bit_cnt;
  logic                ovf_q;
  logic [BW-1:0]       digits_q;
  logic                done_q;
  logic                ovf_out_q;
  logic [DW-1:0]       blink_cnt;
  logic                phase;

  logic [BW-1:0]       adj_work;
  logic [BW-1:0]       shift_work;
  logic                shift_carry;
  logic [7*NUM_DIGITS-1:0] seg_hi;
  logic [3:0]          nib;
  logic [6:0]          pat;
  logic                higher_nz;

  // Handshake: a transfer happens on a rising edge where iValid and oReady are
  // both high. oReady is high only while idle; iValid during a conversion is
  // dropped, not queued, and iNum is never looked at after the transfer edge.
  assign oReady    = (state == S_IDLE);
  assign oDone     = done_q;
  assign oOverflow = ovf_out_q;
  assign dbg_state = state;

  // One double-dabble step: correct nibbles >= 5, then shift {bcd,bin} left.
  always_comb begin
    adj_work = work_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) adj_work[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
    end
    shift_carry = adj_work[BW-1];
    shift_work  = {adj_work[BW-2:0], bin_q[IN_WIDTH-1]};
  end

  // Conversion FSM: IDLE accepts, CONV shifts IN_WIDTH times, LOAD publishes.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state     <= S_IDLE;
      bin_q     <= '0;
      work_q    <= '0;
      bit_cnt   <= '0;
      ovf_q     <= 1'b0;
      digits_q  <= '0;
      done_q    <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iValid) begin
            bin_q   <= iNum;
            work_q  <= '0;
            bit_cnt <= '0;
            ovf_q   <= 1'b0;
            state   <= S_CONV;
          end
        end
        S_CONV: begin
          work_q  <= shift_work;
          bin_q   <= bin_q << 1;
          ovf_q   <= ovf_q | shift_carry;
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == LAST_BIT) state <= S_LOAD;
        end
        S_LOAD: begin
          digits_q  <= work_q;
          ovf_out_q <= ovf_q;
          done_q    <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Free-running blink timebase; phase flips every BLINK_DIV clocks.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_TOP) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + DW'(1);
    end
  end

  // Segment decode, most significant digit first so leading zeros are known.
  // Priority: blink-off blanks all, then overflow dashes, then LZ blanking.
  always_comb begin
    seg_hi    = '0;
    higher_nz = 1'b0;
    nib       = 4'd0;
    pat       = 7'b0000000;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib = digits_q[4*k +: 4];
      if (nib != 4'd0) higher_nz = 1'b1;
      if (iBlink && phase) begin
        pat = 7'b0000000;
      end else if (ovf_out_q) begin
        pat = SEG_DASH;
      end else if (iBlankLZ && (k != 0) && !higher_nz) begin
        pat = 7'b0000000;
      end else begin
        case (nib)
          4'd0:    pat = 7'b0111111;
          4'd1:    pat = 7'b0000110;
          4'd2:    pat = 7'b1011011;
          4'd3:    pat = 7'b1001111;
          4'd4:    pat = 7'b1100110;
          4'd5:    pat = 7'b1101101;
          4'd6:    pat = 7'b1111101;
          4'd7:    pat = 7'b0000111;
          4'd8:    pat = 7'b1111111;
          4'd9:    pat = 7'b1101111;
          default: pat = 7'b0000000;
        endcase
      end
      seg_hi[7*k +: 7] = pat;
    end
    oSeg = ACTIVE_LOW ? ~seg_hi : seg_hi;
  end

endmodule

// File: tb/tb_sevenseg_bcd_display.sv
// Bench for sevenseg_bcd_display: 8 digits, 32-bit input, BLINK_DIV=4,
// active-low segments. Expected displays come from decimal arithmetic.
module tb_sevenseg_bcd_display;

  localparam int ND = 8;

  logic          iClk;
  logic          nRst;
  logic [31:0]   iNum;
  logic          iValid;
  logic          oReady;
  logic          iBlink;
  logic          iBlankLZ;
  logic [55:0]   oSeg;
  logic          oDone;
  logic          oOverflow;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned blink_n;
  logic [31:0] last_val;
  bit          last_lz;

  // Active-high patterns for digits 0..9, order {g,f,e,d,c,b,a}.
  localparam logic [6:0] DIGIT_PAT [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  sevenseg_bcd_display #(
    .NUM_DIGITS(ND), .IN_WIDTH(32), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)
  ) dut (
    .iClk(iClk), .nRst(nRst), .iNum(iNum), .iValid(iValid), .oReady(oReady),
    .iBlink(iBlink), .iBlankLZ(iBlankLZ), .oSeg(oSeg), .oDone(oDone),
    .oOverflow(oOverflow), .dbg_state(dbg_state)
  );

  // Clock and reset-relative cycle count used for the blink phase.
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(posedge iClk or negedge nRst) begin
    if (!nRst) blink_n <= 0;
    else       blink_n <= blink_n + 1;
  end

  // Reference display: digit k is (v / 10^k) % 10; leading zero means v < 10^k.
  function automatic logic [55:0] exp_seg(input longint unsigned v, input bit lz,
                                          input bit blank_all);
    logic [55:0] hi;
    longint unsigned p;
    hi = '0;
    p  = 1;
    if (!blank_all) begin
      for (int k = 0; k < ND; k++) begin
        if (v >= 64'd100000000)
          hi[7*k +: 7] = 7'b1000000;
        else if (k == 0 || !lz || v >= p)
          hi[7*k +: 7] = DIGIT_PAT[int'((v / p) % 10)];
        p = p * 10;
      end
    end
    return ~hi;
  endfunction

  function automatic bit blink_off_now();
    return ((blink_n / 4) % 2) == 1;
  endfunction

  task automatic apply_reset();
    nRst = 1'b0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    nRst = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int cnt;
    cnt = 0;
    while (!oReady && cnt < 100) begin
      @(posedge iClk); @(negedge iClk);
      cnt++;
    end
    n_checks++;
    if (oReady !== 1'b1) $display("FAIL %s wait_ready: oReady=%b after %0d cycles, need 1", tag, oReady, cnt);
    else n_pass++;
  endtask

  // Driver: one handshake, then latency/result/pulse-width checks.
  task automatic convert(input logic [31:0] num, input bit lz, input string tag);
    int cnt;
    logic [55:0] prev;
    logic [55:0] want;
    wait_idle(tag);
    iBlankLZ = lz;
    prev = exp_seg(longint'(last_val), lz, 1'b0);
    iNum = num;
    iValid = 1'b1;
    @(posedge iClk); @(negedge iClk);
    iValid = 1'b0;
    iNum = $urandom;
    cnt = 0;
    while (!oDone && cnt < 100) begin
      if (cnt == 16) begin
        n_checks++;
        if (oSeg !== prev) $display("FAIL %s hold: oSeg=%h need %h", tag, oSeg, prev);
        else n_pass++;
      end
      @(posedge iClk); @(negedge iClk);
      cnt++;
    end
    n_checks++;
    if (cnt != 33) $display("FAIL %s latency: got %0d clocks need 33", tag, cnt);
    else n_pass++;
    want = exp_seg(longint'(num), lz, 1'b0);
    n_checks++;
    if (oSeg !== want) $display("FAIL %s seg: val=%0d oSeg=%h need %h", tag, num, oSeg, want);
    else n_pass++;
    n_checks++;
    if (oOverflow !== (num >= 32'd100000000))
      $display("FAIL %s overflow: val=%0d oOverflow=%b need %b", tag, num, oOverflow, num >= 32'd100000000);
    else n_pass++;
    @(posedge iClk); @(negedge iClk);
    n_checks++;
    if (oDone !== 1'b0) $display("FAIL %s done_width: oDone=%b one cycle later, need 0", tag, oDone);
    else n_pass++;
    last_val = num;
    last_lz  = lz;
  endtask

  task automatic test_reset();
    apply_reset();
    last_val = 0;
    last_lz  = 0;
    n_checks++;
    if (oReady !== 1'b1) $display("FAIL reset_ready: oReady=%b need 1", oReady); else n_pass++;
    n_checks++;
    if (oDone !== 1'b0) $display("FAIL reset_done: oDone=%b need 0", oDone); else n_pass++;
    n_checks++;
    if (oOverflow !== 1'b0) $display("FAIL reset_ovf: oOverflow=%b need 0", oOverflow); else n_pass++;
    n_checks++;
    if (oSeg !== exp_seg(0, 1'b0, 1'b0))
      $display("FAIL reset_seg: oSeg=%h need %h", oSeg, exp_seg(0, 1'b0, 1'b0));
    else n_pass++;
    iBlankLZ = 1'b1;
    #1;
    n_checks++;
    if (oSeg !== exp_seg(0, 1'b1, 1'b0))
      $display("FAIL reset_seg_lz: oSeg=%h need %h", oSeg, exp_seg(0, 1'b1, 1'b0));
    else n_pass++;
  endtask

  task automatic test_basic();
    convert(32'd1234, 1'b0, "basic_1234");
    convert(32'd1234, 1'b1, "lz_1234");
    convert(32'd0, 1'b1, "lz_zero");
    convert(32'd90000001, 1'b1, "lz_inner_zeros");
  endtask

  task automatic test_overflow();
    convert(32'hFFFF_FFFF, 1'b1, "ovf_max");
    convert(32'd99_999_999, 1'b0, "all_nines");
    convert(32'd100_000_000, 1'b0, "ovf_boundary");
    convert(32'd10_000_000, 1'b1, "top_digit");
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 2))
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99_999_999);
        default: v = $urandom_range(0, 9_999);
      endcase
      convert(v, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_blink();
    logic [55:0] want;
    int blanks;
    blanks = 0;
    iBlink = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge iClk); @(negedge iClk);
      want = exp_seg(longint'(last_val), last_lz, blink_off_now());
      if (oSeg === '1) blanks++;
      n_checks++;
      if (oSeg !== want) $display("FAIL blink_on cyc%0d: oSeg=%h need %h", i, oSeg, want);
      else n_pass++;
    end
    n_checks++;
    if (blanks != 8) $display("FAIL blink_duty: blank cycles=%0d need 8", blanks);
    else n_pass++;
    iBlink = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge iClk); @(negedge iClk);
      want = exp_seg(longint'(last_val), last_lz, 1'b0);
      n_checks++;
      if (oSeg !== want) $display("FAIL blink_off cyc%0d: oSeg=%h need %h", i, oSeg, want);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int done_at[$];
    int ready_low;
    a = $urandom_range(0, 99_999_999);
    b = $urandom_range(0, 99_999_999);
    ready_low = 0;
    wait_idle("b2b");
    iBlankLZ = 1'b0;
    iNum = a;
    iValid = 1'b1;
    for (int cyc = 1; cyc <= 68; cyc++) begin
      @(posedge iClk); @(negedge iClk);
      if (cyc <= 34 && !oReady) ready_low++;
      if (oDone) done_at.push_back(cyc);
      if (cyc == 10) iNum = b;
      if (cyc == 45) iNum = $urandom;
      if (cyc == 34) begin
        n_checks++;
        if (oSeg !== exp_seg(longint'(a), 1'b0, 1'b0))
          $display("FAIL b2b_first: val=%0d oSeg=%h need %h", a, oSeg, exp_seg(longint'(a), 1'b0, 1'b0));
        else n_pass++;
      end
      if (cyc == 68) begin
        iValid = 1'b0;
        n_checks++;
        if (oSeg !== exp_seg(longint'(b), 1'b0, 1'b0))
          $display("FAIL b2b_second: val=%0d oSeg=%h need %h", b, oSeg, exp_seg(longint'(b), 1'b0, 1'b0));
        else n_pass++;
      end
    end
    n_checks++;
    if (ready_low != 33) $display("FAIL b2b_ready_low: low for %0d clocks need 33", ready_low);
    else n_pass++;
    n_checks++;
    if (done_at.size() != 2) $display("FAIL b2b_done_count: %0d pulses need 2", done_at.size());
    else n_pass++;
    n_checks++;
    if (done_at.size() < 2 || done_at[0] != 34 || done_at[1] != 68)
      $display("FAIL b2b_done_timing: pulses at %p need 34 and 68", done_at);
    else n_pass++;
    last_val = b;
    last_lz  = 1'b0;
  endtask

  task automatic test_reset_mid();
    int dones;
    convert(32'd5678, 1'b0, "pre_reset");
    iNum = 32'd4321;
    iValid = 1'b1;
    @(posedge iClk); @(negedge iClk);
    iValid = 1'b0;
    repeat (9) begin
      @(posedge iClk); @(negedge iClk);
    end
    nRst = 1'b0;
    #1;
    n_checks++;
    if (oReady !== 1'b1) $display("FAIL midreset_ready: oReady=%b need 1", oReady); else n_pass++;
    n_checks++;
    if (oSeg !== exp_seg(0, 1'b0, 1'b0))
      $display("FAIL midreset_seg: oSeg=%h need %h", oSeg, exp_seg(0, 1'b0, 1'b0));
    else n_pass++;
    n_checks++;
    if (oOverflow !== 1'b0) $display("FAIL midreset_ovf: oOverflow=%b need 0", oOverflow); else n_pass++;
    @(negedge iClk);
    nRst = 1'b1;
    last_val = 0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge iClk); @(negedge iClk);
      if (oDone) dones++;
    end
    n_checks++;
    if (dones != 0) $display("FAIL midreset_no_done: %0d pulses need 0", dones); else n_pass++;
    convert(32'd8765, 1'b1, "post_reset");
  endtask

  initial begin
    iNum = '0;
    iValid = 1'b0;
    iBlink = 1'b0;
    iBlankLZ = 1'b0;
    nRst = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_random();
    test_blink();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
